// File: rtl/johnson_cmd_if.sv
// Command handshake bundle for the Johnson ring sequencer.
// The controller side is the slave; whoever issues runs is the master.
interface johnson_cmd_if #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DIV_W-1:0] cmd_div;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        output cmd_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        input  cmd_div,
        output cmd_ready
    );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-bit Johnson phase counter with
// rate divider, abort, and self-repair of illegal ring codes.
module johnson_seq_ctrl #(
    parameter int  WIDTH = 4,
    parameter int  CNT_W = 8,
    parameter int  DIV_W = 8,
    localparam int PH_W  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    johnson_cmd_if.slave     cmd,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase,
    output logic             step_pulse,
    output logic [CNT_W-1:0] steps_left,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_recover
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] Q_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_left;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_dir;
    logic             r_pulse;
    logic             r_err;
    logic             r_aborted;

    logic             w_legal;
    logic [PH_W-1:0]  w_phase;
    logic             w_due;
    logic [WIDTH-1:0] w_q_next;

    function automatic logic [WIDTH-1:0] jcode(input int k);
        logic [WIDTH-1:0] c;
        for (int i = 0; i < WIDTH; i++) begin
            c[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
        end
        return c;
    endfunction

    // One comparator per legal code yields both the legality flag and the phase.
    always_comb begin
        w_legal = 1'b0;
        w_phase = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (r_q == jcode(k)) begin
                w_legal = 1'b1;
                w_phase = k[PH_W-1:0];
            end
        end
    end

    assign w_due    = (r_div_cnt == r_div);
    assign w_q_next = r_dir ? {~r_q[0], r_q[WIDTH-1:1]}
                            : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_q       <= Q_INIT;
            r_left    <= '0;
            r_div_cnt <= '0;
            r_div     <= '0;
            r_dir     <= 1'b0;
            r_pulse   <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_aborted <= 1'b0;
                    if (cmd.cmd_valid) begin
                        r_dir     <= cmd.cmd_dir;
                        r_div     <= cmd.cmd_div;
                        r_left    <= cmd.cmd_steps;
                        r_div_cnt <= '0;
                        r_state   <= (cmd.cmd_steps == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                    end else if (w_due) begin
                        r_div_cnt <= '0;
                        r_left    <= r_left - CNT_W'(1);
                        // An illegal ring swallows the step; the repair below wins.
                        if (w_legal) begin
                            r_q     <= w_q_next;
                            r_pulse <= 1'b1;
                        end
                        if (r_left == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_aborted <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (!w_legal) begin
                r_q   <= Q_INIT;
                r_err <= 1'b1;
            end
        end
    end

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign q             = r_q;
    assign phase         = w_phase;
    assign step_pulse    = r_pulse;
    assign steps_left    = r_left;
    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign aborted       = r_aborted;
    assign err_recover   = r_err;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: phase-index reference model compared every
// cycle, plus directed runs with literal expectations.
module tb_johnson_seq_ctrl;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic [3:0] q;
    logic [2:0] phase;
    logic       step_pulse;
    logic [7:0] steps_left;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err_recover;

    int n_checks = 0;
    int n_errors = 0;

    johnson_cmd_if #(.CNT_W(8), .DIV_W(8)) cmd_if ();

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(8), .DIV_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .abort      (abort),
        .q          (q),
        .phase      (phase),
        .step_pulse (step_pulse),
        .steps_left (steps_left),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .err_recover(err_recover)
    );

    always #5 clk = ~clk;

    // Johnson code for a phase index: a run of ones grows from bit 0, then
    // shrinks from bit 0 as the zeros march in.
    function automatic logic [3:0] code(input int p);
        if (p <= W) return 4'((1 << p) - 1);
        return 4'(((1 << (2 * W - p)) - 1) << (p - W));
    endfunction

    // Reference model: mode 0 idle, 1 running, 2 completion cycle.
    int m_mode, m_phase, m_left, m_edge, m_div;
    bit m_dir, m_pulse, m_err, m_ab;
    int inj_req = 0;
    int inj_seen = 0;
    bit chk_en = 1'b0;

    always @(posedge clk or negedge reset) begin
        bit inj;
        if (!reset) begin
            m_mode = 0; m_phase = 1; m_left = 0; m_edge = 0;
            m_pulse = 0; m_err = 0; m_ab = 0;
            inj_seen = inj_req;
        end else begin
            m_pulse = 0;
            m_err = 0;
            inj = (inj_req != inj_seen);
            inj_seen = inj_req;
            case (m_mode)
                0: if (cmd_if.cmd_valid) begin
                    m_left = int'(cmd_if.cmd_steps);
                    m_dir  = cmd_if.cmd_dir;
                    m_div  = int'(cmd_if.cmd_div);
                    m_edge = 0;
                    m_mode = (m_left == 0) ? 2 : 1;
                end
                1: if (abort) begin
                    m_mode = 2;
                    m_ab = 1;
                end else begin
                    m_edge++;
                    if (m_edge % (m_div + 1) == 0) begin
                        m_left--;
                        if (!inj) begin
                            m_phase = m_dir ? (m_phase + 2*W - 1) % (2*W)
                                            : (m_phase + 1) % (2*W);
                            m_pulse = 1;
                        end
                        if (m_left == 0) m_mode = 2;
                    end
                end
                default: begin
                    m_mode = 0;
                    m_ab = 0;
                end
            endcase
            if (inj) begin
                m_phase = 1;
                m_err = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic send(input int steps, input bit dir, input int div);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_steps = 8'(steps);
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_div   = 8'(div);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int pulses,
                             output int cycles);
        pulses = 0;
        cycles = 0;
        while (!done && cycles < max) begin
            if (step_pulse) pulses++;
            @(negedge clk);
            cycles++;
        end
        if (step_pulse) pulses++;
        chk("done_within_bound", done, 1);
    endtask

    initial begin
        int pc, cy;
        logic [3:0] exp2 [8];
        logic [3:0] qsave;
        exp2 = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        reset = 1'b0;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_steps = '0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_div   = '0;

        fork
            forever begin
                @(posedge clk);
                #1;
                if (chk_en) begin
                    chk("q", q, code(m_phase));
                    chk("phase", phase, m_phase);
                    chk("step_pulse", step_pulse, m_pulse);
                    chk("steps_left", steps_left, m_left);
                    chk("busy", busy, m_mode == 1);
                    chk("done", done, m_mode == 2);
                    chk("aborted", aborted, m_ab);
                    chk("cmd_ready", cmd_if.cmd_ready, m_mode == 0);
                    chk("err_recover", err_recover, m_err);
                end
            end
        join_none

        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Reset state after idle.
        repeat (5) @(negedge clk);
        chk("rst_q", q, 4'b0001);
        chk("rst_phase", phase, 1);
        chk("rst_ready", cmd_if.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Full forward lap, one step per cycle.
        send(8, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fwd_q", q, exp2[i]);
            chk("fwd_pulse", step_pulse, 1);
            chk("fwd_done", done, i == 7);
        end
        @(negedge clk);
        chk("fwd_ready_after", cmd_if.cmd_ready, 1);

        // Reverse, divided by 3, through the 0 -> 7 wrap.
        send(3, 1'b1, 2);
        wait_done(40, pc, cy);
        chk("rev_pulses", pc, 3);
        chk("rev_q", q, 4'b1100);
        chk("rev_phase", phase, 6);
        chk("rev_aborted", aborted, 0);
        @(negedge clk);

        // Abort after the 4th step.
        send(10, 1'b0, 0);
        pc = 0;
        cy = 0;
        while (pc < 4 && cy < 40) begin
            @(negedge clk);
            cy++;
            if (step_pulse) pc++;
        end
        chk("abt_reached4", pc, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt_done", done, 1);
        chk("abt_aborted", aborted, 1);
        chk("abt_left", steps_left, 6);
        chk("abt_q", q, 4'b0011);
        chk("abt_nopulse", step_pulse, 0);
        @(negedge clk);

        // Zero-step command.
        qsave = q;
        send(0, 1'b0, 0);
        chk("zero_done", done, 1);
        chk("zero_pulse", step_pulse, 0);
        chk("zero_q", q, qsave);
        @(negedge clk);
        chk("zero_done_clr", done, 0);
        chk("zero_ready", cmd_if.cmd_ready, 1);

        // Illegal ring code repaired mid-run, then reset mid-run.
        send(20, 1'b0, 3);
        cy = 0;
        while (!step_pulse && cy < 20) begin
            @(negedge clk);
            cy++;
        end
        chk("inj_first_step", step_pulse, 1);
        force dut.r_q = 4'b0101;
        inj_req++;
        #1;
        release dut.r_q;
        @(negedge clk);
        chk("inj_q", q, 4'b0001);
        chk("inj_err", err_recover, 1);
        chk("inj_busy", busy, 1);
        chk("inj_left", steps_left, 19);
        @(negedge clk);
        chk("inj_err_clr", err_recover, 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_q", q, 4'b0001);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_left", steps_left, 0);
        chk("mid_rst_pulse", step_pulse, 0);
        chk("mid_rst_err", err_recover, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", cmd_if.cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
